// File: rtl/da_filter_pkg.sv
// Shared definitions for the distributed-arithmetic filter datapath:
// default widths and the result-collector state encoding.
package da_filter_pkg;

    localparam int DA_WORD_WIDTH = 16;
    localparam int DA_ACC_WIDTH  = 24;
    localparam int DA_OUT_WIDTH  = 16;
    localparam int DA_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } da_state_t;

endpackage

// File: rtl/da_result_fifo.sv
// Synchronous FIFO with power-of-two depth; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module da_result_fifo
    import da_filter_pkg::*;
#(
    parameter int WIDTH = DA_OUT_WIDTH,
    parameter int DEPTH = DA_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide, so wrap-around modulo DEPTH is free.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; stale entries are unreachable once the
    // pointers and count are cleared, and leaving it unreset keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/da_result_collector.sv
// Collects DA accumulator results at sample boundaries, rounds/saturates
// them to the output width and buffers them behind a valid/ready port.
module da_result_collector
    import da_filter_pkg::*;
#(
    parameter int WORD_WIDTH = DA_WORD_WIDTH,
    parameter int ACC_WIDTH  = DA_ACC_WIDTH,
    parameter int OUT_WIDTH  = DA_OUT_WIDTH,
    parameter int FIFO_DEPTH = DA_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          filter_en,
    input  logic                          ts,
    input  logic [ACC_WIDTH-1:0]          acc_in,
    input  logic                          clr,
    input  logic                          y_ready,
    output logic [OUT_WIDTH-1:0]          y_data,
    output logic                          y_valid,
    output logic                          overflow,
    output logic                          sat,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy
);

    localparam int SHIFT = ACC_WIDTH - OUT_WIDTH;

    if (SHIFT < 1 || WORD_WIDTH < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("da_result_collector: illegal parameter combination");
    end

    localparam logic signed [ACC_WIDTH:0] ROUND   = (ACC_WIDTH+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

    da_state_t state, state_nxt;

    logic signed [ACC_WIDTH:0] rounded;
    logic signed [ACC_WIDTH:0] shifted;
    logic [OUT_WIDTH-1:0]      scaled;
    logic                      scale_sat;
    logic                      capture;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [OUT_WIDTH-1:0]      fifo_head;

    // One extra bit of headroom keeps the rounding add from wrapping.
    assign rounded = $signed({acc_in[ACC_WIDTH-1], acc_in}) + ROUND;
    assign shifted = rounded >>> SHIFT;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        scaled    = shifted[OUT_WIDTH-1:0];
        scale_sat = 1'b0;
        if (shifted > OUT_MAX) begin
            scaled    = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            scale_sat = 1'b1;
        end else if (shifted < OUT_MIN) begin
            scaled    = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            scale_sat = 1'b1;
        end
    end

    assign capture = ts && filter_en && !clr;
    assign pop     = y_valid && y_ready;

    da_result_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .push    (capture),
        .pop     (pop),
        .wr_data (scaled),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign y_valid = !fifo_empty;
    assign y_data  = y_valid ? fifo_head : '0;
    assign busy    = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat      <= 1'b0;
            overflow <= 1'b0;
        end else if (clr) begin
            sat      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (capture && scale_sat)           sat      <= 1'b1;
            if (capture && fifo_full && !pop)   overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (filter_en) state_nxt = RUN;
            end
            RUN: begin
                if (!filter_en) state_nxt = (level != '0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (filter_en)                   state_nxt = RUN;
                else if (level == '0 || clr)     state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_da_result_collector.sv
// Directed bench for da_result_collector with a queue scoreboard of
// expected output samples.
module tb_da_result_collector;

    localparam int WORD_WIDTH = 16;
    localparam int ACC_WIDTH  = 24;
    localparam int OUT_WIDTH  = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int SHIFT      = ACC_WIDTH - OUT_WIDTH;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 filter_en;
    logic                 ts;
    logic [ACC_WIDTH-1:0] acc_in;
    logic                 clr;
    logic                 y_ready;
    logic [OUT_WIDTH-1:0] y_data;
    logic                 y_valid;
    logic                 overflow;
    logic                 sat;
    logic [LVL_W-1:0]     level;
    logic                 busy;

    da_result_collector #(
        .WORD_WIDTH (WORD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .filter_en (filter_en),
        .ts        (ts),
        .acc_in    (acc_in),
        .clr       (clr),
        .y_ready   (y_ready),
        .y_data    (y_data),
        .y_valid   (y_valid),
        .overflow  (overflow),
        .sat       (sat),
        .level     (level),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [OUT_WIDTH-1:0] sb_q [$];
    bit                   exp_sat = 1'b0;
    bit                   exp_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round-half-up, floor shift, clamp -- written with plain integers.
    function automatic logic [OUT_WIDTH-1:0] model_scale(input logic [ACC_WIDTH-1:0] a,
                                                        output bit s);
        int v;
        int r;
        v = int'($signed(a));
        r = (v + (1 << (SHIFT - 1))) >>> SHIFT;
        s = 1'b0;
        if (r > (1 << (OUT_WIDTH - 1)) - 1) begin
            r = (1 << (OUT_WIDTH - 1)) - 1;
            s = 1'b1;
        end else if (r < -(1 << (OUT_WIDTH - 1))) begin
            r = -(1 << (OUT_WIDTH - 1));
            s = 1'b1;
        end
        return r[OUT_WIDTH-1:0];
    endfunction

    // Check pre-edge outputs against the model, advance the model, clock.
    task automatic tick();
        bit                   pop;
        bit                   s;
        logic [OUT_WIDTH-1:0] v;
        check("y_valid", y_valid, sb_q.size() != 0);
        if (sb_q.size() != 0) check("y_data_head", y_data, sb_q[0]);
        check("level", level, sb_q.size());
        pop = (sb_q.size() != 0) && y_ready;
        if (clr) begin
            sb_q.delete();
            exp_sat = 1'b0;
            exp_ovf = 1'b0;
        end else begin
            if (pop) void'(sb_q.pop_front());
            if (ts && filter_en) begin
                v = model_scale(acc_in, s);
                if (s) exp_sat = 1'b1;
                if (sb_q.size() < FIFO_DEPTH) sb_q.push_back(v);
                else                          exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("overflow", overflow, exp_ovf);
        check("sat", sat, exp_sat);
    endtask

    task automatic capture(input logic [ACC_WIDTH-1:0] a);
        ts     = 1'b1;
        acc_in = a;
        tick();
        ts     = 1'b0;
        acc_in = '0;
    endtask

    task automatic gap();
        repeat (WORD_WIDTH - 1) tick();
    endtask

    task automatic flush();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        filter_en = 1'b0;
        ts        = 1'b0;
        acc_in    = '0;
        clr       = 1'b0;
        y_ready   = 1'b0;

        #12;
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sat", sat, 0);
        check("rst_busy", busy, 0);

        @(negedge clk);
        rst_n     = 1'b1;
        filter_en = 1'b1;
        y_ready   = 1'b1;
        tick();
        check("first_edge_busy", busy, 1);

        // Rounding and saturation corner values.
        capture(24'h000180);
        check("round_y_data", y_data, 16'h0002);
        check("round_sat", sat, 0);
        tick();
        capture(24'h7FFFFF);
        check("pos_sat_y_data", y_data, 16'h7FFF);
        check("pos_sat_flag", sat, 1);
        tick();
        capture(24'h800000);
        check("neg_min_y_data", y_data, 16'h8000);
        tick();
        capture(24'hFFFF7F);
        check("neg_round_y_data", y_data, 16'hFFFF);
        tick();
        flush();
        check("clr_sat", sat, 0);

        // Overflow with a stalled consumer, then ordered drain.
        y_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            capture(ACC_WIDTH'(k * 256));
            gap();
        end
        check("ovf_level", level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", y_data, 16'h0001);
        y_ready = 1'b1;
        repeat (4) tick();
        check("ovf_drained", level, 0);
        flush();

        // Push into a full FIFO while popping on the same edge.
        y_ready = 1'b0;
        for (int k = 1; k <= 4; k++) capture(ACC_WIDTH'(k * 24'h001000));
        check("full_level", level, 4);
        y_ready = 1'b1;
        capture(24'h00AB00);
        check("full_pop_level", level, 4);
        check("full_pop_ovf", overflow, 0);
        repeat (4) tick();
        y_ready = 1'b0;
        check("full_pop_drained", level, 0);

        // Drain after filter_en falls; ts without filter_en is ignored.
        capture(24'h003300);
        capture(24'hFFC000);
        check("drain_level", level, 2);
        filter_en = 1'b0;
        tick();
        check("drain_busy", busy, 1);
        ts     = 1'b1;
        acc_in = 24'h7FFFFF;
        tick();
        ts     = 1'b0;
        acc_in = '0;
        check("ts_ignored_level", level, 2);
        check("ts_ignored_sat", sat, 0);
        y_ready = 1'b1;
        tick();
        tick();
        y_ready = 1'b0;
        check("drain_empty", level, 0);
        tick();
        check("drain_idle", busy, 0);
        ts = 1'b1;
        tick();
        ts = 1'b0;
        check("idle_ts_ignored", level, 0);

        // Asynchronous reset mid-stream discards buffered results.
        filter_en = 1'b1;
        tick();
        for (int k = 1; k <= 3; k++) capture(ACC_WIDTH'(k * 24'h000200));
        check("pre_rst_level", level, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_y_valid", y_valid, 0);
        check("async_rst_level", level, 0);
        check("async_rst_overflow", overflow, 0);
        check("async_rst_busy", busy, 0);
        sb_q.delete();
        exp_sat = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        capture(24'h000180);
        check("post_rst_y_data", y_data, 16'h0002);
        y_ready = 1'b1;
        tick();
        check("post_rst_level", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
